// File: rtl/pe_grid_pkg.sv
// Shared sizing and FSM state encoding for the PE grid feeder.
package pe_grid_pkg;

  localparam int DATA_W       = 16;
  localparam int TAG_W        = 4;
  localparam int MAX_ROWS     = 12;
  localparam int MAX_COLS     = 14;
  localparam int DRAIN_CYCLES = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

endpackage

// File: rtl/pe_grid_feeder_tag_sequencer.sv
// One bus of the feeder: clamps the job count, accepts beats from an upstream
// ready/valid stream and re-emits each beat with its sequential tag.
module tag_sequencer #(
  parameter int MAX    = 12,
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [TAG_W-1:0]         count,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_valid,
  output logic                     finished
);

  localparam logic [TAG_W-1:0] MAX_T = TAG_W'(MAX);

  function automatic logic [TAG_W-1:0] sat_count(input logic [TAG_W-1:0] n);
    return (n > MAX_T) ? MAX_T : n;
  endfunction

  logic [TAG_W-1:0]         cnt_p0;
  logic [TAG_W-1:0]         lim_p0;
  logic                     hs_p0;
  logic signed [DATA_W-1:0] data_p1;
  logic [TAG_W-1:0]         tag_p1;
  logic                     vld_p1;

  // Input stage: a beat is only accepted when it still has a tag to use.
  always_comb begin
    in_ready = enable && (cnt_p0 < lim_p0);
    hs_p0    = in_ready && in_valid;
    // Looks one beat ahead so the FSM can leave SEND on the last handshake.
    finished = (cnt_p0 == lim_p0) || (hs_p0 && ((cnt_p0 + 1'b1) == lim_p0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      lim_p0 <= '0;
    end else if (load) begin
      cnt_p0 <= '0;
      lim_p0 <= sat_count(count);
    end else if (hs_p0) begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // Output stage: registered value/tag hold between beats, valid pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      tag_p1  <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= hs_p0;
      if (hs_p0) begin
        data_p1 <= in_data;
        tag_p1  <= cnt_p0;
      end
    end
  end

  assign out_data  = data_p1;
  assign out_tag   = tag_p1;
  assign out_valid = vld_p1;

endmodule

// File: rtl/pe_grid_feeder.sv
// Tagged-multicast transmitter feeding weights (row tags) and activations
// (column tags) into the PE grid, with a settle period before done.
module pe_grid_feeder #(
  parameter int DATA_W       = pe_grid_pkg::DATA_W,
  parameter int TAG_W        = pe_grid_pkg::TAG_W,
  parameter int MAX_ROWS     = pe_grid_pkg::MAX_ROWS,
  parameter int MAX_COLS     = pe_grid_pkg::MAX_COLS,
  parameter int DRAIN_CYCLES = pe_grid_pkg::DRAIN_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [TAG_W-1:0]         num_rows,
  input  logic [TAG_W-1:0]         num_cols,
  input  logic signed [DATA_W-1:0] w_data,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic signed [DATA_W-1:0] a_data,
  input  logic                     a_valid,
  output logic                     a_ready,
  output logic signed [DATA_W-1:0] weight_val_out,
  output logic [TAG_W-1:0]         tag_row,
  output logic                     valid_y,
  output logic signed [DATA_W-1:0] image_val_out,
  output logic [TAG_W-1:0]         tag_col,
  output logic                     valid_x,
  output logic                     busy,
  output logic                     done
);

  import pe_grid_pkg::*;

  localparam int DRAIN_CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_CW-1:0] DRAIN_LAST = DRAIN_CW'(DRAIN_CYCLES - 1);

  feeder_state_e       state, state_nxt;
  logic [DRAIN_CW-1:0] drain_cnt;
  logic                load;
  logic                sending;
  logic                w_fin;
  logic                a_fin;

  assign sending = (state == SEND);

  tag_sequencer #(
    .MAX    (MAX_ROWS),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_w_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .count     (num_rows),
    .enable    (sending),
    .in_data   (w_data),
    .in_valid  (w_valid),
    .in_ready  (w_ready),
    .out_data  (weight_val_out),
    .out_tag   (tag_row),
    .out_valid (valid_y),
    .finished  (w_fin)
  );

  tag_sequencer #(
    .MAX    (MAX_COLS),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_a_seq (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .count     (num_cols),
    .enable    (sending),
    .in_data   (a_data),
    .in_valid  (a_valid),
    .in_ready  (a_ready),
    .out_data  (image_val_out),
    .out_tag   (tag_col),
    .out_valid (valid_x),
    .finished  (a_fin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        // Leaves on the last handshake edge, so the final valid overlaps DRAIN.
        if (w_fin && a_fin) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_pe_grid_feeder.sv
// Directed bench for pe_grid_feeder: tag sequencing, backpressure, clamping,
// drain timing, ignored restarts and mid-job reset.
module tb_pe_grid_feeder;

  localparam int DW = 16;
  localparam int TW = 4;
  localparam int D  = 6;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [TW-1:0]        num_rows;
  logic [TW-1:0]        num_cols;
  logic signed [DW-1:0] w_data;
  logic                 w_valid;
  logic                 w_ready;
  logic signed [DW-1:0] a_data;
  logic                 a_valid;
  logic                 a_ready;
  logic signed [DW-1:0] weight_val_out;
  logic [TW-1:0]        tag_row;
  logic                 valid_y;
  logic signed [DW-1:0] image_val_out;
  logic [TW-1:0]        tag_col;
  logic                 valid_x;
  logic                 busy;
  logic                 done;

  pe_grid_feeder dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_rows       (num_rows),
    .num_cols       (num_cols),
    .w_data         (w_data),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .a_data         (a_data),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .weight_val_out (weight_val_out),
    .tag_row        (tag_row),
    .valid_y        (valid_y),
    .image_val_out  (image_val_out),
    .tag_col        (tag_col),
    .valid_x        (valid_x),
    .busy           (busy),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic signed [DW-1:0] wsrc [32];
  logic signed [DW-1:0] asrc [32];

  // Log of everything the grid would see, captured mid-cycle.
  int                   vy_n, vx_n, done_n, done_cyc;
  logic [TW-1:0]        vy_tag [32];
  logic [TW-1:0]        vx_tag [32];
  logic signed [DW-1:0] vy_val [32];
  logic signed [DW-1:0] vx_val [32];
  int                   vy_cyc [32];
  int                   vx_cyc [32];
  logic signed [DW-1:0] pe_w, pe_a;

  always @(posedge clk) cyc++;

  // cyc equals the index of the most recent rising edge here.
  always @(negedge clk) begin
    if (valid_y && vy_n < 32) begin
      vy_tag[vy_n] = tag_row;
      vy_val[vy_n] = weight_val_out;
      vy_cyc[vy_n] = cyc;
      vy_n++;
      if (tag_row == 4'd3) pe_w = weight_val_out;
    end
    if (valid_x && vx_n < 32) begin
      vx_tag[vx_n] = tag_col;
      vx_val[vx_n] = image_val_out;
      vx_cyc[vx_n] = cyc;
      vx_n++;
      if (tag_col == 4'd5) pe_a = image_val_out;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  task automatic clear_log();
    vy_n = 0; vx_n = 0; done_n = 0; done_cyc = -1;
    pe_w = '0; pe_a = '0;
  endtask

  // Runs one job; returns the edge index at which start was sampled.
  task automatic run_job(input int rows, input int cols, input bit w_toggle,
                         input int restart_iter, output int se);
    int  w_idx, a_idx, it;
    bit  hs_w, hs_a;
    clear_log();
    num_rows = TW'(rows);
    num_cols = TW'(cols);
    start    = 1'b1;
    se       = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    w_idx = 0; a_idx = 0; it = 0;
    while (done_n == 0 && it < 300) begin
      w_valid = w_toggle ? it[0] : 1'b1;
      w_data  = wsrc[w_idx];
      a_valid = 1'b1;
      a_data  = asrc[a_idx];
      if (it == restart_iter) begin
        start    = 1'b1;
        num_rows = 4'd12;
        num_cols = 4'd14;
      end
      hs_w = w_valid && w_ready;
      hs_a = a_valid && a_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (hs_w && w_idx < 31) w_idx++;
      if (hs_a && a_idx < 31) a_idx++;
      it++;
    end
    w_valid = 1'b0;
    a_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (valid_y !== 1'b0) begin failures++; $display("FAIL reset_valid_y got=%0b want=0", valid_y); end
    checks++; if (valid_x !== 1'b0) begin failures++; $display("FAIL reset_valid_x got=%0b want=0", valid_x); end
    checks++; if (weight_val_out !== 16'sd0 || tag_row !== 4'd0) begin failures++; $display("FAIL reset_wbus got=%0d/%0d want=0/0", weight_val_out, tag_row); end
    checks++; if (image_val_out !== 16'sd0 || tag_col !== 4'd0) begin failures++; $display("FAIL reset_abus got=%0d/%0d want=0/0", image_val_out, tag_col); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_ctrl got busy=%0b done=%0b want=0/0", busy, done); end
    checks++; if (w_ready !== 1'b0 || a_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b%0b want=00", w_ready, a_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_pe();
    int se;
    run_job(4, 6, 1'b0, -1, se);
    checks++; if (vy_n !== 4) begin failures++; $display("FAIL single_vy_count got=%0d want=4", vy_n); end
    checks++; if (vx_n !== 6) begin failures++; $display("FAIL single_vx_count got=%0d want=6", vx_n); end
    checks++; if (vy_tag[3] !== 4'd3 || vy_val[3] !== 16'sd10) begin failures++; $display("FAIL single_row3 got tag=%0d val=%0d want 3/10", vy_tag[3], vy_val[3]); end
    checks++; if (vx_tag[5] !== 4'd5 || vx_val[5] !== 16'sd4) begin failures++; $display("FAIL single_col5 got tag=%0d val=%0d want 5/4", vx_tag[5], vx_val[5]); end
    checks++; if (32'(pe_w) * 32'(pe_a) !== 32'sd40) begin failures++; $display("FAIL single_psum got=%0d want=40", 32'(pe_w) * 32'(pe_a)); end
    // Last beat (activation 5) at edge se+6; done visible after edge se+6+D.
    checks++; if (done_n !== 1 || done_cyc !== se + 12) begin failures++; $display("FAIL single_done got n=%0d cyc=%0d want 1/%0d", done_n, done_cyc, se + 12); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%0b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    int se;
    run_job(12, 14, 1'b0, -1, se);
    checks++; if (vy_n !== 12 || vx_n !== 14) begin failures++; $display("FAIL full_counts got=%0d/%0d want 12/14", vy_n, vx_n); end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (vy_tag[i] !== 4'(i) || vy_cyc[i] !== se + 1 + i || vy_val[i] !== 16'(7 + i)) begin
        failures++; $display("FAIL full_row_beat%0d got tag=%0d cyc=%0d val=%0d want %0d/%0d/%0d", i, vy_tag[i], vy_cyc[i], vy_val[i], i, se + 1 + i, 7 + i);
      end
    end
    for (int i = 0; i < 14; i++) begin
      checks++;
      if (vx_tag[i] !== 4'(i) || vx_cyc[i] !== se + 1 + i || vx_val[i] !== 16'(i - 1)) begin
        failures++; $display("FAIL full_col_beat%0d got tag=%0d cyc=%0d val=%0d want %0d/%0d/%0d", i, vx_tag[i], vx_cyc[i], vx_val[i], i, se + 1 + i, i - 1);
      end
    end
    // Last handshake at edge se+14; done is sampled by edge se+14+D+1.
    checks++; if (done_cyc !== se + 14 + D) begin failures++; $display("FAIL full_done got=%0d want=%0d", done_cyc, se + 14 + D); end
  endtask

  task automatic test_backpressure();
    int se;
    run_job(4, 2, 1'b1, -1, se);
    checks++; if (vy_n !== 4) begin failures++; $display("FAIL bp_count got=%0d want=4", vy_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (vy_tag[i] !== 4'(i) || vy_val[i] !== 16'(7 + i) || vy_cyc[i] !== se + 2 + 2 * i) begin
        failures++; $display("FAIL bp_beat%0d got tag=%0d val=%0d cyc=%0d want %0d/%0d/%0d", i, vy_tag[i], vy_val[i], vy_cyc[i], i, 7 + i, se + 2 + 2 * i);
      end
    end
    checks++; if (done_cyc !== se + 8 + D) begin failures++; $display("FAIL bp_done got=%0d want=%0d", done_cyc, se + 8 + D); end
  endtask

  task automatic test_clamp_zero();
    int se;
    run_job(15, 0, 1'b0, -1, se);
    checks++; if (vy_n !== 12 || vx_n !== 0) begin failures++; $display("FAIL clamp_counts got=%0d/%0d want 12/0", vy_n, vx_n); end
    checks++; if (vy_tag[11] !== 4'd11) begin failures++; $display("FAIL clamp_last_tag got=%0d want=11", vy_tag[11]); end
    checks++; if (done_cyc !== se + 12 + D) begin failures++; $display("FAIL clamp_done got=%0d want=%0d", done_cyc, se + 12 + D); end
    run_job(0, 0, 1'b0, -1, se);
    checks++; if (vy_n !== 0 || vx_n !== 0) begin failures++; $display("FAIL zero_pulses got=%0d/%0d want 0/0", vy_n, vx_n); end
    // Sampled by edge se+D+2, visible right after edge se+D+1.
    checks++; if (done_n !== 1 || done_cyc !== se + D + 1) begin failures++; $display("FAIL zero_done got n=%0d cyc=%0d want 1/%0d", done_n, done_cyc, se + D + 1); end
  endtask

  task automatic test_start_while_busy();
    int se;
    run_job(3, 3, 1'b0, 1, se);
    checks++; if (vy_n !== 3 || vx_n !== 3) begin failures++; $display("FAIL restart_counts got=%0d/%0d want 3/3", vy_n, vx_n); end
    checks++; if (done_cyc !== se + 3 + D) begin failures++; $display("FAIL restart_done got=%0d want=%0d", done_cyc, se + 3 + D); end
    repeat (30) @(posedge clk);
    #1;
    checks++; if (done_n !== 1 || busy !== 1'b0) begin failures++; $display("FAIL restart_queued got done_n=%0d busy=%0b want 1/0", done_n, busy); end
  endtask

  task automatic test_reset_mid_send();
    int se, it;
    clear_log();
    num_rows = 4'd12;
    num_cols = 4'd14;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    w_valid = 1'b1; a_valid = 1'b1;
    w_data = wsrc[0]; a_data = asrc[0];
    it = 0;
    while (vy_n < 5 && it < 50) begin
      @(posedge clk); #1;
      w_data = wsrc[it + 1]; a_data = asrc[it + 1];
      it++;
    end
    @(negedge clk);
    checks++; if (vy_n !== 5) begin failures++; $display("FAIL rstmid_reach5 got=%0d want=5", vy_n); end
    w_valid = 1'b0; a_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (valid_y !== 1'b0 || valid_x !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got vy=%0b vx=%0b busy=%0b want 0", valid_y, valid_x, busy); end
    checks++; if (weight_val_out !== 16'sd0 || tag_row !== 4'd0 || image_val_out !== 16'sd0 || tag_col !== 4'd0) begin failures++; $display("FAIL rstmid_data got %0d/%0d/%0d/%0d want 0", weight_val_out, tag_row, image_val_out, tag_col); end
    clear_log();
    repeat (20) @(posedge clk);
    #1;
    checks++; if (done_n !== 0 || vy_n !== 0 || vx_n !== 0) begin failures++; $display("FAIL rstmid_quiet got done=%0d vy=%0d vx=%0d want 0", done_n, vy_n, vx_n); end
    run_job(2, 3, 1'b0, -1, se);
    checks++; if (vy_n !== 2 || vx_n !== 3 || vy_tag[0] !== 4'd0 || vx_tag[0] !== 4'd0) begin failures++; $display("FAIL rstmid_clean got vy=%0d vx=%0d t0=%0d/%0d want 2/3/0/0", vy_n, vx_n, vy_tag[0], vx_tag[0]); end
    checks++; if (done_cyc !== se + 3 + D) begin failures++; $display("FAIL rstmid_clean_done got=%0d want=%0d", done_cyc, se + 3 + D); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0;
    num_rows = '0; num_cols = '0;
    w_data = '0; w_valid = 1'b0; a_data = '0; a_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wsrc[i] = 16'(7 + i);
      asrc[i] = 16'(i - 1);
    end
    clear_log();
    test_reset();
    test_single_pe();
    test_back_to_back();
    test_backpressure();
    test_clamp_zero();
    test_start_while_busy();
    test_reset_mid_send();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_grid_feeder.md
# pe_grid_feeder

Tagged-multicast transmitter for the 12x14 PE grid. It pulls weights and activations from two upstream ready/valid streams and drives the grid's weight bus (weight value, row tag, valid_y) and activation bus (image value, column tag, valid_x). Each value is stamped with a sequential row or column tag so that the grid's tag-matching PEs capture it. It sits between the global buffer and `PE_Grid_12x14`, and signals `done` once the grid has had time to settle.

## Interface
- DATA_W, 16, value width on all data paths
- TAG_W, 4, row/column tag width
- MAX_ROWS, 12, grid rows; row tags 0..MAX_ROWS-1
- MAX_COLS, 14, grid columns; column tags 0..MAX_COLS-1
- DRAIN_CYCLES, 6, wait cycles after the last emission before `done`

- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle job request; sampled only in IDLE
- num_rows  in  TAG_W  rows to load this job; latched at start
- num_cols  in  TAG_W  columns to load this job; latched at start
- w_data  in  DATA_W  upstream weight
- w_valid  in  1  upstream weight valid
- w_ready  out  1  feeder accepts weight
- a_data  in  DATA_W  upstream activation
- a_valid  in  1  upstream activation valid
- a_ready  out  1  feeder accepts activation
- weight_val_out  out  DATA_W  to grid weight_val_in
- tag_row  out  TAG_W  to grid tag_row
- valid_y  out  1  to grid valid_y
- image_val_out  out  DATA_W  to grid image_val_in
- tag_col  out  TAG_W  to grid tag_col
- valid_x  out  1  to grid valid_x
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, SEND, DRAIN, DONE.
- IDLE, start=1: latch the clamped counts, clear both counters, go to SEND. A count above MAX is clamped to MAX; a count of 0 means that bus emits nothing.
- SEND: the weight and activation channels run independently and concurrently.
  - Weight channel: w_ready = (w_cnt < rows_lat).
  - On a w_valid & w_ready handshake, register weight_val_out = w_data, tag_row = w_cnt, valid_y = 1, then increment w_cnt.
  - With no handshake, valid_y = 0. weight_val_out and tag_row hold their previous values.
  - Activation channel: identical, using a_cnt, cols_lat, tag_col and valid_x.
- SEND -> DRAIN when both counters have reached their limits, including the case where both counts were 0 at start.
- DRAIN: w_ready = a_ready = 0. The drain counter counts DRAIN_CYCLES cycles, then the block goes to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.
- start while not in IDLE is ignored (not queued).
- Upstream data is never dropped. A ready is only asserted when the beat will be forwarded.

## Timing
- Reset values: all outputs are 0, state = IDLE, all counters = 0.
- rst mid-job aborts the job at the next edge. No further valid_x/valid_y pulses and no done pulse follow.
- Start latency: start high at edge t puts the block in SEND at t+1. w_ready/a_ready can be high in the cycle after start is sampled.
- Forward latency: a handshake at edge t gives valid_y/valid_x high during cycle t..t+1. The tag equals the index of that beat.
- Throughput: one beat per cycle per bus; the two buses are independent.
- The last beat's valid is high in the cycle the FSM enters DRAIN. done rises DRAIN_CYCLES+1 cycles after the last handshake edge.
- busy = state != IDLE; busy is low in the cycle after done.
- Tags wrap only through clamping and never exceed MAX-1.

## Structure
- Package `pe_grid_pkg`:
  - DATA_W, TAG_W, MAX_ROWS, MAX_COLS
  - feeder state enum
- Sub-module `tag_sequencer`:
  - One instance per bus, parameterised by MAX.
  - Contains the limit latch and clamp, the beat counter, ready generation, the registered data/tag/valid output, and a `finished` flag.
- The top level contains the FSM, the drain counter, and the done/busy logic.

## Test plan
- Single-PE load: num_rows=4, num_cols=6, w stream 10 at index 3, a stream 4 at index 5, grid attached with psum_ins=0.
  - Required: tag_row=3 carries 10 and tag_col=5 carries 4.
  - Required: psum_outs[5] includes 40 after done.
  - Required: exactly 4 valid_y and 6 valid_x pulses.
- Full grid, back-to-back: upstream always valid, num_rows=12, num_cols=14.
  - Required: tags 0..11 and 0..13 on consecutive cycles.
  - Required: done at handshake_last+DRAIN_CYCLES+1.
- Backpressure: w_valid toggles every other cycle.
  - Required: no tag is skipped or duplicated, values arrive in order, and valid_y is low on idle cycles.
- Clamp and zero:
  - num_rows=15 gives exactly 12 weight beats.
  - num_rows=0, num_cols=0: done arrives DRAIN_CYCLES+2 cycles after start and no valid pulses are issued.
- start while busy: a second start in mid-SEND is ignored and its counts are not latched.
- Reset mid-SEND at beat 5: outputs are 0 next cycle, no done pulse, and a subsequent start runs a clean job from tag 0.
